spi_frame_ctrl: RTL and testbench

SPI master frame controller for the stepper-driver serial link. It accepts a parallel command word, drives cs_n/sclk/mosi in SPI mode 3 (CPOL=1, CPHA=1), and shifts the word out LSB first. On each rising sclk it samples miso and presents the bit to the downstream sipo deserializer as a one-cycle enable plus data bit. After SIZE bits the sipo holds the received word, right-aligned with the first bit at bit 0.

---
 rtl/spi_frame_ctrl.sv | 169 ++++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_ctrl.sv
// SPI master frame controller, mode 3 (CPOL=1, CPHA=1), LSB first.
// Shifts one SIZE-bit command word out on mosi_out. Every rising sclk_out
// hands the sampled miso_in bit to a downstream deserializer as a one-cycle
// strobe. Frame sequence: IDLE -> LEAD -> SHIFT -> TRAIL -> GAP -> IDLE.
// Every output comes straight from a flop, so sclk_out and cs_n_out cannot glitch.

module spi_frame_ctrl #(
    parameter int SIZE    = 40,   // frame length in bits
    parameter int CLK_DIV = 4     // clk_in cycles per sclk half-period
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            start_in,
    input  logic [SIZE-1:0] data_in,
    output logic            ready_out,
    input  logic            miso_in,
    output logic            sclk_out,
    output logic            cs_n_out,
    output logic            mosi_out,
    output logic            sipo_data_out,
    output logic            sipo_en_out,
    output logic            done_out
);

    // Counter widths: the half-period counter never has to hold CLK_DIV
    // itself, and the bit counter saturates at SIZE.
    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(SIZE + 1);

    // The terminal count of one half-period, and the rise index of the last bit.
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        GAP
    } state_t;

    state_t          state_reg;
    logic [HW-1:0]   half_cnt_reg;   // cycles spent in the current half-period
    logic [BW-1:0]   bit_cnt_reg;    // rising sclk edges issued this frame
    logic [SIZE-1:0] shift_reg;      // bit 0 is always the bit on mosi_out
    logic [SIZE-1:0] shift_next;     // shift_reg moved one place towards bit 0
    logic            half_tick;      // last cycle of the current half-period

    // Build the right-shifted word. Zeros enter at the top so that the
    // register drains to zero. For SIZE=1 this is just a single zero bit.
    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_shift
            if (gi == SIZE - 1) begin : g_top
                assign shift_next[gi] = 1'b0;
            end else begin : g_mid
                assign shift_next[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    // A half-period ends after CLK_DIV cycles. The counter restarts from 0
    // whenever a tick is consumed.
    assign half_tick = (half_cnt_reg == HALF_LAST);

    // mosi_out is taken directly from the low flop of the shift register.
    // Clearing the register at frame end therefore returns mosi_out to 0.
    assign mosi_out = shift_reg[0];

    // Frame sequencer. The state, the counters, the shift register and all
    // the registered outputs are updated together in this one block.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg     <= IDLE;
            half_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            cs_n_out      <= 1'b1;
            sclk_out      <= 1'b1;
            sipo_en_out   <= 1'b0;
            sipo_data_out <= 1'b0;
            done_out      <= 1'b0;
            ready_out     <= 1'b1;
        end else begin
            // Strobes last exactly one cycle unless a state re-asserts them.
            sipo_en_out <= 1'b0;
            done_out    <= 1'b0;

            case (state_reg)
                IDLE: begin
                    half_cnt_reg <= '0;
                    if (start_in) begin
                        // Capture the word now. Any later change on data_in
                        // during the frame is ignored.
                        shift_reg   <= data_in;
                        bit_cnt_reg <= '0;
                        cs_n_out    <= 1'b0;
                        ready_out   <= 1'b0;
                        state_reg   <= LEAD;
                    end
                end

                LEAD: begin
                    // Setup time from cs_n fall to the first sclk fall.
                    // This fall does not advance mosi, so bit 0 stays on the line.
                    if (half_tick) begin
                        half_cnt_reg <= '0;
                        sclk_out     <= 1'b0;
                        state_reg    <= SHIFT;
                    end else begin
                        half_cnt_reg <= half_cnt_reg + 1'b1;
                    end
                end

                SHIFT: begin
                    if (half_tick) begin
                        half_cnt_reg <= '0;
                        if (!sclk_out) begin
                            // Rising edge: this is where the slave's data is sampled.
                            sclk_out      <= 1'b1;
                            sipo_en_out   <= 1'b1;
                            sipo_data_out <= miso_in;
                            bit_cnt_reg   <= bit_cnt_reg + 1'b1;
                            if (bit_cnt_reg == BIT_LAST) begin
                                // Final rise. sclk stays high from here on.
                                state_reg <= TRAIL;
                            end
                        end else begin
                            // Falling edge: put the next bit on mosi.
                            sclk_out  <= 1'b0;
                            shift_reg <= shift_next;
                        end
                    end else begin
                        half_cnt_reg <= half_cnt_reg + 1'b1;
                    end
                end

                TRAIL: begin
                    // Hold time after the last rise, then release the slave.
                    if (half_tick) begin
                        half_cnt_reg <= '0;
                        cs_n_out     <= 1'b1;
                        done_out     <= 1'b1;
                        shift_reg    <= '0;
                        state_reg    <= GAP;
                    end else begin
                        half_cnt_reg <= half_cnt_reg + 1'b1;
                    end
                end

                GAP: begin
                    // Keeps cs_n high for at least one half-period between frames.
                    if (half_tick) begin
                        half_cnt_reg <= '0;
                        ready_out    <= 1'b1;
                        state_reg    <= IDLE;
                    end else begin
                        half_cnt_reg <= half_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl. There are three instances:
//   A: SIZE=8, CLK_DIV=2 for the basic, loopback, random and mid-frame reset cases.
//   B: SIZE=4, CLK_DIV=1 for back-to-back frames.
//   C: SIZE=1, CLK_DIV=1 for the minimum configuration.
// The expected waveform is computed from the phase within the frame using
// plain arithmetic on the frame timing rules.

module tb_spi_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // ---------------- instance A ----------------
    logic       start_a, ready_a, miso_a, miso_drv_a, loop_a;
    logic [7:0] data_a;
    logic       sclk_a, cs_n_a, mosi_a, sd_a, en_a, done_a;
    assign miso_a = loop_a ? mosi_a : miso_drv_a;

    spi_frame_ctrl #(.SIZE(8), .CLK_DIV(2)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_a), .data_in(data_a),
        .ready_out(ready_a), .miso_in(miso_a), .sclk_out(sclk_a), .cs_n_out(cs_n_a),
        .mosi_out(mosi_a), .sipo_data_out(sd_a), .sipo_en_out(en_a), .done_out(done_a)
    );

    // ---------------- instance B ----------------
    logic       start_b, ready_b, miso_b;
    logic [3:0] data_b;
    logic       sclk_b, cs_n_b, mosi_b, sd_b, en_b, done_b;

    spi_frame_ctrl #(.SIZE(4), .CLK_DIV(1)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_b), .data_in(data_b),
        .ready_out(ready_b), .miso_in(miso_b), .sclk_out(sclk_b), .cs_n_out(cs_n_b),
        .mosi_out(mosi_b), .sipo_data_out(sd_b), .sipo_en_out(en_b), .done_out(done_b)
    );

    // ---------------- instance C ----------------
    logic       start_c, ready_c, miso_c;
    logic [0:0] data_c;
    logic       sclk_c, cs_n_c, mosi_c, sd_c, en_c, done_c;

    spi_frame_ctrl #(.SIZE(1), .CLK_DIV(1)) dut_c (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_c), .data_in(data_c),
        .ready_out(ready_c), .miso_in(miso_c), .sclk_out(sclk_c), .cs_n_out(cs_n_c),
        .mosi_out(mosi_c), .sipo_data_out(sd_c), .sipo_en_out(en_c), .done_out(done_c)
    );

    // Expected outputs as a function of the phase. Phase ph is the number of
    // cycles after the first cycle with cs_n low (cycle c after accept has ph=c-1).
    typedef struct packed {
        logic cs_n;
        logic sclk;
        logic mosi;
        logic en;
        logic done;
        logic ready;
    } exp_t;

    function automatic exp_t model(input int ph, input int s, input int d, input logic [63:0] w);
        exp_t e;
        int   idx;
        e.cs_n  = !(ph < (2*s+1)*d);
        e.sclk  = !(ph >= d && ph < 2*s*d && ((ph / d) % 2 == 1));
        idx     = (ph < d) ? 0 : (ph - d) / (2*d);
        if (idx > s - 1) idx = s - 1;
        e.mosi  = (ph < (2*s+1)*d) ? w[idx] : 1'b0;
        e.en    = (ph > 0) && (ph % (2*d) == 0) && (ph <= 2*s*d);
        e.done  = (ph == (2*s+1)*d);
        e.ready = (ph >= (2*s+2)*d);
        return e;
    endfunction

    // Results recorded by the most recent instance-A frame.
    logic       miso_hist_a [0:63];
    int         t_cs_low, t_sclk_low, t_done, t_ready, t_en_first, t_en_last, en_count;
    logic [7:0] sipo_word, mosi_word;

    // Runs one complete frame on A, comparing every cycle against the model.
    // When noise is set, start_in is toggled and data_in is scrambled during the frame.
    task automatic run_frame_a(input logic [7:0] d, input bit loop, input bit noise);
        exp_t e;
        t_cs_low = -1; t_sclk_low = -1; t_done = -1; t_ready = -1;
        t_en_first = -1; t_en_last = -1; en_count = 0;
        sipo_word = '0; mosi_word = '0;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b1) begin
            errors++;
            $display("FAIL a_ready_before_start: got %b want 1", ready_a);
        end
        start_a = 1'b1; data_a = d; loop_a = loop; miso_drv_a = 1'($urandom);
        #1 miso_hist_a[0] = miso_a;
        for (int c = 1; c <= 37; c++) begin
            @(negedge clk);
            e = model(c - 1, 8, 2, {56'b0, d});
            checks++;
            if ({cs_n_a, sclk_a, mosi_a, en_a, done_a, ready_a} !== e) begin
                errors++;
                $display("FAIL a_frame cycle %0d: cs_n/sclk/mosi/en/done/ready got %b want %b",
                         c, {cs_n_a, sclk_a, mosi_a, en_a, done_a, ready_a}, e);
            end
            if (e.en) begin
                checks++;
                if (sd_a !== miso_hist_a[c-1]) begin
                    errors++;
                    $display("FAIL a_sipo_data cycle %0d: got %b want %b", c, sd_a, miso_hist_a[c-1]);
                end
            end
            if (cs_n_a === 1'b0 && t_cs_low < 0) t_cs_low = c;
            if (sclk_a === 1'b0 && t_sclk_low < 0) t_sclk_low = c;
            if (done_a === 1'b1 && t_done < 0) t_done = c;
            if (ready_a === 1'b1 && t_ready < 0) t_ready = c;
            if (en_a === 1'b1) begin
                if (t_en_first < 0) t_en_first = c;
                t_en_last = c;
                en_count++;
                if (en_count <= 8) begin
                    sipo_word[en_count-1] = sd_a;
                    mosi_word[en_count-1] = mosi_a;
                end
            end
            start_a    = (noise && c < 37) ? 1'($urandom) : 1'b0;
            data_a     = noise ? 8'($urandom) : d;
            miso_drv_a = 1'($urandom);
            #1 miso_hist_a[c] = miso_a;
        end
        start_a = 1'b0;
        loop_a  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cs_n_a, sclk_a, mosi_a, en_a, done_a, ready_a, sd_a} !== 7'b1100010) begin
            errors++;
            $display("FAIL reset_a: got %b want 1100010", {cs_n_a, sclk_a, mosi_a, en_a, done_a, ready_a, sd_a});
        end
        checks++;
        if ({cs_n_b, sclk_b, mosi_b, en_b, done_b, ready_b, sd_b} !== 7'b1100010) begin
            errors++;
            $display("FAIL reset_b: got %b want 1100010", {cs_n_b, sclk_b, mosi_b, en_b, done_b, ready_b, sd_b});
        end
        checks++;
        if ({cs_n_c, sclk_c, mosi_c, en_c, done_c, ready_c, sd_c} !== 7'b1100010) begin
            errors++;
            $display("FAIL reset_c: got %b want 1100010", {cs_n_c, sclk_c, mosi_c, en_c, done_c, ready_c, sd_c});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        run_frame_a(8'hA5, 1'b0, 1'b0);
        checks++;
        if (t_cs_low !== 1 || t_sclk_low !== 3) begin
            errors++;
            $display("FAIL basic_lead: cs_n low at %0d sclk low at %0d, want 1 and 3", t_cs_low, t_sclk_low);
        end
        checks++;
        if (t_en_first !== 5 || t_en_last !== 33 || en_count !== 8) begin
            errors++;
            $display("FAIL basic_sipo_en: first %0d last %0d count %0d, want 5 33 8", t_en_first, t_en_last, en_count);
        end
        checks++;
        if (t_done !== 35 || t_ready !== 37) begin
            errors++;
            $display("FAIL basic_end: done at %0d ready at %0d, want 35 and 37", t_done, t_ready);
        end
        checks++;
        if (mosi_word !== 8'hA5) begin
            errors++;
            $display("FAIL basic_mosi_seq: got %h want a5", mosi_word);
        end
        $display("basic frame a5: done at %0d ready at %0d", t_done, t_ready);
    endtask

    task automatic test_loopback;
        run_frame_a(8'h3C, 1'b1, 1'b0);
        checks++;
        if (sipo_word !== 8'h3C || en_count !== 8) begin
            errors++;
            $display("FAIL loopback_word: got %h count %0d want 3c count 8", sipo_word, en_count);
        end
        $display("loopback frame 3c: sipo word %h", sipo_word);
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic [7:0] want;
        bit         lp;
        for (int n = 0; n < 6; n++) begin
            d  = 8'($urandom);
            lp = 1'($urandom);
            run_frame_a(d, lp, 1'b1);
            // Rise k appears in cycle 1+4k and captures miso from cycle 4k.
            for (int k = 1; k <= 8; k++) want[k-1] = miso_hist_a[4*k];
            checks++;
            if (sipo_word !== want || en_count !== 8) begin
                errors++;
                $display("FAIL random_sipo_word frame %0d: got %h count %0d want %h count 8", n, sipo_word, en_count, want);
            end
            $display("random frame %0d data %h loop %0d sipo %h", n, d, lp, sipo_word);
        end
    endtask

    task automatic test_reset_mid_frame;
        @(negedge clk);
        start_a = 1'b1; data_a = 8'($urandom); loop_a = 1'b0; miso_drv_a = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        // Cycle 13 carries the third rising edge.
        checks++;
        if (en_a !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre_en: got %b want 1", en_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cs_n_a, sclk_a, mosi_a, en_a, done_a, ready_a} !== 6'b110001) begin
            errors++;
            $display("FAIL midreset_immediate: got %b want 110001", {cs_n_a, sclk_a, mosi_a, en_a, done_a, ready_a});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (en_a !== 1'b0 || done_a !== 1'b0 || cs_n_a !== 1'b1) begin
                errors++;
                $display("FAIL midreset_quiet %0d: en %b done %b cs_n %b want 0 0 1", i, en_a, done_a, cs_n_a);
            end
        end
        rst_n = 1'b1;
        $display("reset mid-frame applied, restarting");
        run_frame_a(8'($urandom), 1'b1, 1'b0);
        checks++;
        if (sipo_word !== data_a || en_count !== 8) begin
            errors++;
            $display("FAIL midreset_next_frame: got %h count %0d want %h count 8", sipo_word, en_count, data_a);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] acc [2];
        logic       hist [0:31];
        exp_t       e;
        int         f, c, rise_t, fall2_t;
        logic       prev_cs;
        rise_t = -1; fall2_t = -1;
        @(negedge clk);
        start_b = 1'b1; data_b = 4'($urandom); acc[0] = data_b; miso_b = 1'($urandom);
        hist[0] = miso_b; prev_cs = cs_n_b;
        for (int g = 1; g <= 22; g++) begin
            @(negedge clk);
            f = (g <= 11) ? 0 : 1;
            c = g - 11*f;
            e = model(c - 1, 4, 1, {60'b0, acc[f]});
            checks++;
            if ({cs_n_b, sclk_b, mosi_b, en_b, done_b, ready_b} !== e) begin
                errors++;
                $display("FAIL b2b cycle %0d: cs_n/sclk/mosi/en/done/ready got %b want %b",
                         g, {cs_n_b, sclk_b, mosi_b, en_b, done_b, ready_b}, e);
            end
            if (e.en) begin
                checks++;
                if (sd_b !== hist[g-1]) begin
                    errors++;
                    $display("FAIL b2b_sipo_data cycle %0d: got %b want %b", g, sd_b, hist[g-1]);
                end
            end
            if (prev_cs === 1'b0 && cs_n_b === 1'b1 && rise_t < 0) rise_t = g;
            if (prev_cs === 1'b1 && cs_n_b === 1'b0 && rise_t >= 0 && fall2_t < 0) fall2_t = g;
            prev_cs = cs_n_b;
            data_b  = 4'($urandom);
            if (g == 11) acc[1] = data_b;
            start_b = (g < 22);
            miso_b  = 1'($urandom);
            hist[g] = miso_b;
        end
        start_b = 1'b0;
        checks++;
        if (rise_t !== 10 || fall2_t - rise_t !== 2) begin
            errors++;
            $display("FAIL b2b_gap: cs_n rise at %0d next fall at %0d, want 10 and 12", rise_t, fall2_t);
        end
        $display("back-to-back frames %h %h: gap %0d cycles", acc[0], acc[1], fall2_t - rise_t);
    endtask

    task automatic test_min_config;
        exp_t e;
        @(negedge clk);
        start_c = 1'b1; data_c = 1'b1; miso_c = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start_c = 1'b0;
            e = model(c - 1, 1, 1, 64'd1);
            checks++;
            if ({cs_n_c, sclk_c, mosi_c, en_c, done_c, ready_c} !== e) begin
                errors++;
                $display("FAIL min cycle %0d: cs_n/sclk/mosi/en/done/ready got %b want %b",
                         c, {cs_n_c, sclk_c, mosi_c, en_c, done_c, ready_c}, e);
            end
            if (c == 3) begin
                checks++;
                if (en_c !== 1'b1 || sd_c !== 1'b1) begin
                    errors++;
                    $display("FAIL min_sipo cycle 3: en %b data %b want 1 1", en_c, sd_c);
                end
            end
            if (c == 4) begin
                checks++;
                if (done_c !== 1'b1 || cs_n_c !== 1'b1) begin
                    errors++;
                    $display("FAIL min_done cycle 4: done %b cs_n %b want 1 1", done_c, cs_n_c);
                end
            end
        end
        $display("min config frame: ready %b at cycle 5", ready_c);
    endtask

    initial begin
        start_a = 1'b0; data_a = '0; miso_drv_a = 1'b0; loop_a = 1'b0;
        start_b = 1'b0; data_b = '0; miso_b = 1'b0;
        start_c = 1'b0; data_c = '0; miso_c = 1'b0;
        test_reset();
        test_basic();
        test_loopback();
        test_random();
        test_reset_mid_frame();
        test_back_to_back();
        test_min_config();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
